// File: rtl/dual_rail_capture.sv
// ---------------------------------------------------------------------------
// dual_rail_capture
//
// Receives N independent dual-rail channels from an asynchronous sender.
// Each channel's completion flag is synchronised into clk; when it is seen
// high and the channel's one-entry output buffer can take a word, the
// single-rail word (the rail1 value of every bit) is latched and a 4-phase
// return-to-zero acknowledge is raised. Ack drops once the synchronised
// completion flag returns to zero (spacer seen). Captured words leave on a
// per-channel valid/ready stream.
//
// Ports
//   clk        in   1        single clock
//   reset      in   1        asynchronous, active-high reset
//   rail0      in   N*BITS   0-rail per bit, channel n at [n*BITS +: BITS]
//   rail1      in   N*BITS   1-rail per bit, same packing
//   done       in   N        completion flag per channel (asynchronous)
//   ack        out  N        4-phase acknowledge to the sender, registered
//   out_data   out  N*BITS   captured word per channel (rail1 value)
//   out_valid  out  N        buffer holds an undelivered word
//   out_ready  in   N        consumer accepts when out_valid & out_ready
//   err        out  N        sticky encoding error per channel
//   state_dbg  out  N        per-channel FSM state (1 = ACKED, 0 = IDLE)
//
// Stream handshake: a word moves on every rising clk edge where
// out_valid[n] and out_ready[n] are both high; out_valid never drops without
// such a transfer, and out_ready while out_valid is low has no effect.
// ---------------------------------------------------------------------------
module dual_rail_capture #(
    parameter int N           = 2,
    parameter int BITS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N*BITS-1:0]   rail0,
    input  logic [N*BITS-1:0]   rail1,
    input  logic [N-1:0]        done,
    output logic [N-1:0]        ack,
    output logic [N*BITS-1:0]   out_data,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [N-1:0]        err,
    output logic [N-1:0]        state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    // Synchroniser chain: stage 0 samples the raw asynchronous flag.
    logic [N-1:0]      sync_q [SYNC_STAGES];
    logic [N-1:0]      sync_d [SYNC_STAGES];
    logic [N-1:0]      done_s;

    state_t            state_q [N];
    state_t            state_d [N];
    logic [N-1:0]      ack_q, ack_d;
    logic [N-1:0]      valid_q, valid_d;
    logic [N-1:0]      err_q, err_d;
    logic [N-1:0]      capture;
    logic [N*BITS-1:0] data_q, data_d;

    always_comb begin
        sync_d[0] = done;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Only the completion flag crosses domains; the rails are guaranteed
    // stable by the 4-phase protocol while done=1 and ack=0.
    assign done_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        ack_d   = ack_q;
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        capture = '0;
        for (int n = 0; n < N; n++) begin
            state_d[n] = state_q[n];
            if (state_q[n] == IDLE) begin
                // Buffer is free when empty or draining this same edge.
                // When full, stay in IDLE with ack low: that is the
                // backpressure seen by the sender.
                if (done_s[n] && (!valid_q[n] || out_ready[n])) begin
                    capture[n]  = 1'b1;
                    state_d[n]  = ACKED;
                    ack_d[n]    = 1'b1;
                end
            end else begin
                // Holding ACKED until the spacer is seen means a done held
                // high can never produce a second capture.
                if (!done_s[n]) begin
                    state_d[n] = IDLE;
                    ack_d[n]   = 1'b0;
                end
            end

            if (capture[n]) begin
                data_d[n*BITS +: BITS] = rail1[n*BITS +: BITS];
                valid_d[n]             = 1'b1;
                // A bit with equal rails is neither a valid 0 nor 1; the
                // word is still delivered but the error sticks.
                if (|(~(rail0[n*BITS +: BITS] ^ rail1[n*BITS +: BITS]))) begin
                    err_d[n] = 1'b1;
                end
            end else if (valid_q[n] && out_ready[n]) begin
                valid_d[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int n = 0; n < N; n++) begin
                state_q[n] <= IDLE;
            end
            ack_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int n = 0; n < N; n++) begin
                state_q[n] <= state_d[n];
            end
            ack_q   <= ack_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_dbg = '0;
        for (int n = 0; n < N; n++) begin
            state_dbg[n] = (state_q[n] == ACKED);
        end
    end

    assign ack       = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dual_rail_capture.sv
// ---------------------------------------------------------------------------
// tb_dual_rail_capture
//
// Drives 4-phase dual-rail transfers into dual_rail_capture and checks the
// captured stream. Each issued word is pushed onto its channel's expected
// queue; a monitor pops and compares whenever a word is transferred.
// ---------------------------------------------------------------------------
module tb_dual_rail_capture;

    localparam int N    = 2;
    localparam int BITS = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [N*BITS-1:0]   rail0;
    logic [N*BITS-1:0]   rail1;
    logic [N-1:0]        done;
    logic [N-1:0]        ack;
    logic [N*BITS-1:0]   out_data;
    logic [N-1:0]        out_valid;
    logic [N-1:0]        out_ready;
    logic [N-1:0]        err;
    logic [N-1:0]        state_dbg;

    dual_rail_capture #(.N(N), .BITS(BITS), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rail0     (rail0),
        .rail1     (rail1),
        .done      (done),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int              checks = 0;
    int              fails  = 0;
    logic [BITS-1:0] exp_q0[$];
    logic [BITS-1:0] exp_q1[$];
    logic [N-1:0]    err_exp = '0;
    int              pop_cnt[N];
    int              ack_rise[N];
    logic [N-1:0]    ack_prev = '0;
    logic [BITS-1:0] mon_e;
    bit              rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding: rail0 is the complement of rail1, except that an
    // illegal word has one bit with both rails equal.
    function automatic logic [BITS-1:0] make_r0(input logic [BITS-1:0] w, input bit bad);
        logic [BITS-1:0] r0;
        int k;
        r0 = ~w;
        if (bad) begin
            k = $urandom_range(0, BITS-1);
            r0[k] = w[k];
        end
        return r0;
    endfunction

    function automatic bit word_is_bad(input logic [BITS-1:0] w, input logic [BITS-1:0] r0);
        for (int i = 0; i < BITS; i++) begin
            if (w[i] == r0[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_exp(input int n, input logic [BITS-1:0] w);
        if (n == 0) exp_q0.push_back(w);
        else        exp_q1.push_back(w);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            for (int n = 0; n < N; n++) begin
                if (ack[n] && !ack_prev[n]) ack_rise[n]++;
                if (out_valid[n] && out_ready[n]) begin
                    pop_cnt[n]++;
                    if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_pop ch%0d: got %0h expected nothing at %0t",
                                 n, out_data[n*BITS +: BITS], $time);
                    end else begin
                        if (n == 0) mon_e = exp_q0.pop_front();
                        else        mon_e = exp_q1.pop_front();
                        check($sformatf("pop_data_ch%0d", n), out_data[n*BITS +: BITS], mon_e);
                    end
                end
            end
        end
        ack_prev = ack;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input int n, input logic lvl, input string nm);
        int cyc;
        cyc = 0;
        while (ack[n] !== lvl && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(nm, ack[n], lvl);
    endtask

    task automatic present(input int n, input logic [BITS-1:0] w, input logic [BITS-1:0] r0);
        rail1[n*BITS +: BITS] = w;
        rail0[n*BITS +: BITS] = r0;
        done[n] = 1'b1;
        push_exp(n, w);
        err_exp[n] = err_exp[n] | word_is_bad(w, r0);
    endtask

    task automatic spacer(input int n);
        done[n] = 1'b0;
        rail1[n*BITS +: BITS] = '0;
        rail0[n*BITS +: BITS] = '0;
    endtask

    task automatic send(input int n, input logic [BITS-1:0] w, input logic [BITS-1:0] r0);
        @(posedge clk); #1;
        present(n, w, r0);
        wait_ack(n, 1'b1, "ack_rise");
        check("err_after_capture", err[n], err_exp[n]);
        @(posedge clk); #1;
        spacer(n);
        wait_ack(n, 1'b0, "ack_fall");
    endtask

    task automatic drain(input int cycles);
        @(posedge clk); #1;
        out_ready = '1;
        repeat (cycles) @(posedge clk);
        #1;
        out_ready = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int pc;
        int ar;
        logic [BITS-1:0] w;
        reset     = 1'b1;
        rail0     = '0;
        rail1     = '0;
        done      = '0;
        out_ready = '0;
        for (int n = 0; n < N; n++) begin
            pop_cnt[n]  = 0;
            ack_rise[n] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_ack", ack, 0);
        check("reset_valid", out_valid, 0);
        check("reset_err", err, 0);
        check("reset_data", out_data, 0);
        check("reset_state", state_dbg, 0);

        // 1: single capture latency on ch0
        @(posedge clk); #1;
        present(0, 32'hDEADBEEF, ~32'hDEADBEEF);
        @(posedge clk);                 // edge 0: done first sampled
        @(posedge clk);                 // edge 1
        @(negedge clk);
        check("t1_valid_edge1", out_valid[0], 0);
        check("t1_ack_edge1", ack[0], 0);
        @(posedge clk);                 // edge 2
        @(negedge clk);
        check("t1_valid_edge2", out_valid[0], 1);
        check("t1_data_edge2", out_data[31:0], 32'hDEADBEEF);
        check("t1_ack_edge2", ack[0], 1);
        check("t1_ch1_valid", out_valid[1], 0);
        check("t1_ch1_data", out_data[63:32], 0);
        check("t1_ch1_ack", ack[1], 0);

        // 2: backpressure, then same-edge drain and refill
        @(posedge clk); #1;
        spacer(0);
        wait_ack(0, 1'b0, "t2_ack_fall");
        @(posedge clk); #1;
        present(0, 32'h12345678, ~32'h12345678);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t2_ack_stalled", ack[0], 0);
        check("t2_data_held", out_data[31:0], 32'hDEADBEEF);
        check("t2_valid_held", out_valid[0], 1);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check("t2_refill_data", out_data[31:0], 32'h12345678);
        check("t2_refill_ack", ack[0], 1);
        check("t2_refill_valid", out_valid[0], 1);
        @(posedge clk); #1;
        spacer(0);
        wait_ack(0, 1'b0, "t2_ack_fall2");
        drain(3);

        // 3: back-to-back words with ready held
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        pc = pop_cnt[0];
        ar = ack_rise[0];
        for (int i = 1; i <= 4; i++) begin
            send(0, BITS'(i), ~BITS'(i));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t3_pops", pop_cnt[0] - pc, 4);
        check("t3_ack_rises", ack_rise[0] - ar, 4);
        check("t3_queue_empty", exp_q0.size(), 0);

        // 4: encoding error on bit 5 is sticky
        w = 32'hA5A5A5A5;
        send(0, w, (~w) | 32'h20);
        check("t4_err0", err[0], 1);
        check("t4_err1", err[1], 0);
        send(0, 32'h0F0F0F0F, ~32'h0F0F0F0F);
        check("t4_err0_sticky", err[0], 1);
        @(posedge clk); #1;
        out_ready = '0;

        // 6: both channels on the same edge, independent drain
        @(posedge clk); #1;
        present(0, 32'h11111111, ~32'h11111111);
        present(1, 32'h22222222, ~32'h22222222);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t6_both_valid", out_valid, 2'b11);
        check("t6_both_ack", ack, 2'b11);
        @(posedge clk); #1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        @(negedge clk);
        check("t6_ch1_drained_first", out_valid, 2'b01);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check("t6_ch0_drained", out_valid, 2'b00);
        @(posedge clk); #1;
        spacer(0);
        spacer(1);
        wait_ack(0, 1'b0, "t6_ack0_fall");
        wait_ack(1, 1'b0, "t6_ack1_fall");

        // 5: reset mid-handshake on ch1, then duplicate recapture
        w = 32'hCAFEF00D;
        @(posedge clk); #1;
        present(1, w, (~w) ^ 32'h1);
        wait_ack(1, 1'b1, "t5_ack_rise");
        check("t5_err_before", err[1], 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("t5_reset_ack", ack, 0);
        check("t5_reset_valid", out_valid, 0);
        check("t5_reset_err", err, 0);
        exp_q0.delete();
        exp_q1.delete();
        err_exp = '0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp(1, w);
        err_exp[1] = 1'b1;
        @(posedge clk);                 // edge 1
        @(posedge clk);                 // edge 2
        @(negedge clk);
        check("t5_valid_edge2", out_valid[1], 0);
        @(posedge clk);                 // edge 3
        @(negedge clk);
        check("t5_recapture_valid", out_valid[1], 1);
        check("t5_recapture_data", out_data[63:32], w);
        check("t5_recapture_ack", ack[1], 1);
        check("t5_recapture_err", err[1], 1);
        @(posedge clk); #1;
        spacer(1);
        wait_ack(1, 1'b0, "t5_ack_fall");
        drain(3);

        // random traffic on both channels with random consumer readiness
        rand_done = 1'b0;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 30; i++) begin
                            logic [BITS-1:0] rw;
                            rw = $urandom;
                            send(0, rw, make_r0(rw, $urandom_range(0, 7) == 0));
                        end
                    end
                    begin
                        for (int i = 0; i < 30; i++) begin
                            logic [BITS-1:0] rw;
                            rw = $urandom;
                            send(1, rw, make_r0(rw, $urandom_range(0, 7) == 0));
                        end
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = N'($urandom_range(0, 3));
                end
            end
        join
        drain(4);
        @(negedge clk);
        check("final_q0_empty", exp_q0.size(), 0);
        check("final_q1_empty", exp_q1.size(), 0);
        check("final_err", err, err_exp);
        check("final_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
